// File: rtl/stream_mux_3_1.sv
// Three-input stream multiplexer with round-robin arbitration into a single
// registered output slot, plus a mod-256 counter of words delivered downstream.
module stream_mux_3_1 #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [2:0]       din_valid,
  output logic [2:0]       din_ready,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       dout_sel,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [7:0]       xfer_cnt
);

  logic [1:0]       r_last;
  logic [WIDTH-1:0] r_dout;
  logic [1:0]       r_sel;
  logic             r_valid;
  logic [7:0]       r_cnt;

  logic             w_load_en;
  logic             w_gnt_any;
  logic [1:0]       w_gnt_idx;
  logic [1:0]       w_ord0;
  logic [1:0]       w_ord1;
  logic [1:0]       w_ord2;
  logic [2:0]       w_ready;
  logic [WIDTH-1:0] w_gnt_data;

  // Search order starts one past the last granted channel.
  always_comb begin
    w_ord0 = 2'd0;
    w_ord1 = 2'd1;
    w_ord2 = 2'd2;
    case (r_last)
      2'd0: begin
        w_ord0 = 2'd1;
        w_ord1 = 2'd2;
        w_ord2 = 2'd0;
      end
      2'd1: begin
        w_ord0 = 2'd2;
        w_ord1 = 2'd0;
        w_ord2 = 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_gnt_any = |din_valid;
    w_gnt_idx = w_ord2;
    if (din_valid[w_ord0]) begin
      w_gnt_idx = w_ord0;
    end else if (din_valid[w_ord1]) begin
      w_gnt_idx = w_ord1;
    end
  end

  always_comb begin
    case (w_gnt_idx)
      2'd0:    w_gnt_data = din0;
      2'd1:    w_gnt_data = din1;
      default: w_gnt_data = din2;
    endcase
  end

  assign w_load_en = !r_valid || dout_ready;
  assign w_ready   = (!rst && w_load_en && w_gnt_any) ? (3'b001 << w_gnt_idx) : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_dout  <= '0;
      r_sel   <= 2'd0;
      r_last  <= 2'd2;
      r_cnt   <= '0;
    end else begin
      if (r_valid && dout_ready) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_load_en) begin
        if (w_gnt_any) begin
          r_dout  <= w_gnt_data;
          r_sel   <= w_gnt_idx;
          r_last  <= w_gnt_idx;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign din_ready  = w_ready;
  assign dout       = r_dout;
  assign dout_sel   = r_sel;
  assign dout_valid = r_valid;
  assign xfer_cnt   = r_cnt;

endmodule

// File: tb/tb_stream_mux_3_1.sv
// Self-checking bench for stream_mux_3_1: directed scenarios plus a randomized
// run checked against an arithmetic round-robin reference model and scoreboard.
module tb_stream_mux_3_1;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din0 = '0;
  logic [W-1:0] din1 = '0;
  logic [W-1:0] din2 = '0;
  logic [2:0]   din_valid = '0;
  logic [2:0]   din_ready;
  logic [W-1:0] dout;
  logic [1:0]   dout_sel;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic [7:0]   xfer_cnt;

  stream_mux_3_1 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .din0(din0), .din1(din1), .din2(din2),
    .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_sel(dout_sel), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit           m_valid = 1'b0;
  logic [W-1:0] m_dout = '0;
  int           m_sel = 0;
  int           m_last = 2;
  int           m_cnt = 0;

  function automatic logic [2:0] exp_ready();
    if (rst) return 3'b000;
    if (m_valid && !dout_ready) return 3'b000;
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (din_valid[c]) return 3'(1 << c);
    end
    return 3'b000;
  endfunction

  function automatic logic [13:0] exp_out();
    return {m_valid, 2'(m_sel), m_dout, 8'(m_cnt)};
  endfunction

  function automatic logic [W-1:0] din_of(input int c);
    if (c == 0) return din0;
    if (c == 1) return din1;
    return din2;
  endfunction

  task automatic step();
    logic [2:0] g;
    @(posedge clk);
    g = exp_ready();
    if (rst) begin
      m_valid = 1'b0; m_dout = '0; m_sel = 0; m_last = 2; m_cnt = 0;
    end else begin
      if (m_valid && dout_ready) m_cnt = (m_cnt + 1) % 256;
      if (g != 3'b000) begin
        m_sel   = g[0] ? 0 : (g[1] ? 1 : 2);
        m_dout  = din_of(m_sel);
        m_valid = 1'b1;
        m_last  = m_sel;
      end else if (!m_valid || dout_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 3'b000; dout_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 3'b111; dout_ready = 1'b1;
    din0 = 3'd1; din1 = 3'd2; din2 = 3'd3;
    #2;
    n_vec++;
    if (din_ready !== 3'b000) begin
      n_err++; $display("FAIL reset_ready: got %b expected 000", din_ready);
    end
    step();
    n_vec++;
    if ({dout_valid, dout_sel, dout, xfer_cnt} !== 14'd0) begin
      n_err++; $display("FAIL reset_state: got v=%b sel=%0d d=%0d cnt=%0d expected all 0",
                        dout_valid, dout_sel, dout, xfer_cnt);
    end
    rst = 1'b0;
    #2;
    n_vec++;
    if (din_ready !== 3'b001) begin
      n_err++; $display("FAIL reset_first_grant: got %b expected 001", din_ready);
    end
    step();
    n_vec++;
    if (dout_valid !== 1'b1 || dout_sel !== 2'd0 || dout !== 3'd1) begin
      n_err++; $display("FAIL reset_first_word: got v=%b sel=%0d d=%0d expected 1/0/1",
                        dout_valid, dout_sel, dout);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    din0 = 3'd1; din1 = 3'd2; din2 = 3'd3; din_valid = 3'b111; dout_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #2;
      n_vec++;
      if (din_ready !== 3'(1 << (i % 3))) begin
        n_err++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, din_ready, 3'(1 << (i % 3)));
      end
      step();
      n_vec++;
      if (dout_sel !== 2'(i % 3) || dout !== 3'(i % 3 + 1) || dout_valid !== 1'b1 || xfer_cnt !== 8'(i)) begin
        n_err++; $display("FAIL rr_out[%0d]: got sel=%0d d=%0d v=%b cnt=%0d expected %0d/%0d/1/%0d",
                          i, dout_sel, dout, dout_valid, xfer_cnt, i % 3, i % 3 + 1, i);
      end
    end
  endtask

  task automatic test_single_channel();
    do_reset();
    din0 = 3'd7; din1 = 3'd5; din2 = 3'd4; din_valid = 3'b010; dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      n_vec++;
      if (din_ready !== 3'b010) begin
        n_err++; $display("FAIL single_ready[%0d]: got %b expected 010", i, din_ready);
      end
      step();
      n_vec++;
      if (dout !== 3'd5 || dout_sel !== 2'd1 || dout_valid !== 1'b1 || xfer_cnt !== 8'(i)) begin
        n_err++; $display("FAIL single_out[%0d]: got d=%0d sel=%0d v=%b cnt=%0d expected 5/1/1/%0d",
                          i, dout, dout_sel, dout_valid, xfer_cnt, i);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    din2 = 3'd6; din_valid = 3'b100; dout_ready = 1'b0;
    step();
    n_vec++;
    if (dout !== 3'd6 || dout_sel !== 2'd2 || dout_valid !== 1'b1) begin
      n_err++; $display("FAIL stall_load: got d=%0d sel=%0d v=%b expected 6/2/1", dout, dout_sel, dout_valid);
    end
    din0 = 3'd1; din1 = 3'd2; din2 = 3'd7; din_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_vec++;
      if (din_ready !== 3'b000) begin
        n_err++; $display("FAIL stall_ready[%0d]: got %b expected 000", i, din_ready);
      end
      step();
      n_vec++;
      if (dout !== 3'd6 || dout_sel !== 2'd2 || dout_valid !== 1'b1 || xfer_cnt !== 8'd0) begin
        n_err++; $display("FAIL stall_hold[%0d]: got d=%0d sel=%0d v=%b cnt=%0d expected 6/2/1/0",
                          i, dout, dout_sel, dout_valid, xfer_cnt);
      end
    end
    dout_ready = 1'b1;
    #2;
    n_vec++;
    if (din_ready !== 3'b001) begin
      n_err++; $display("FAIL stall_release_ready: got %b expected 001", din_ready);
    end
    step();
    n_vec++;
    if (xfer_cnt !== 8'd1 || dout !== 3'd1 || dout_sel !== 2'd0 || dout_valid !== 1'b1) begin
      n_err++; $display("FAIL stall_release: got cnt=%0d d=%0d sel=%0d v=%b expected 1/1/0/1",
                        xfer_cnt, dout, dout_sel, dout_valid);
    end
  endtask

  task automatic test_idle_withdraw();
    do_reset();
    din_valid = 3'b000; dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      step();
      n_vec++;
      if (dout_valid !== 1'b0 || din_ready !== 3'b000) begin
        n_err++; $display("FAIL idle[%0d]: got v=%b ready=%b expected 0/000", i, dout_valid, din_ready);
      end
    end
    din0 = 3'd3; din_valid = 3'b001;
    step();
    din1 = 3'd4; din_valid = 3'b010;
    step();
    step();
    din1 = 3'd4; din2 = 3'd2; din_valid = 3'b100; dout_ready = 1'b1;
    #2;
    n_vec++;
    if (din_ready !== 3'b100) begin
      n_err++; $display("FAIL withdraw_ready: got %b expected 100", din_ready);
    end
    step();
    n_vec++;
    if (dout_sel !== 2'd2 || dout !== 3'd2 || xfer_cnt !== 8'd1) begin
      n_err++; $display("FAIL withdraw_out: got sel=%0d d=%0d cnt=%0d expected 2/2/1", dout_sel, dout, xfer_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    din0 = 3'd1; din_valid = 3'b001; dout_ready = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      step();
      n_vec++;
      if (xfer_cnt !== 8'(m_cnt)) begin
        n_err++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", k, xfer_cnt, m_cnt);
      end
      if (k == 256) begin
        n_vec++;
        if (xfer_cnt !== 8'd255) begin
          n_err++; $display("FAIL wrap_255: got %0d expected 255", xfer_cnt);
        end
      end
    end
    n_vec++;
    if (xfer_cnt !== 8'd0) begin
      n_err++; $display("FAIL wrap_zero: got %0d expected 0", xfer_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    din0 = 3'd1; din1 = 3'd2; din2 = 3'd3; din_valid = 3'b111; dout_ready = 1'b1;
    repeat (3) step();
    dout_ready = 1'b0;
    step();
    rst = 1'b1;
    #2;
    n_vec++;
    if (din_ready !== 3'b000) begin
      n_err++; $display("FAIL midrst_ready: got %b expected 000", din_ready);
    end
    step();
    n_vec++;
    if (dout_valid !== 1'b0 || xfer_cnt !== 8'd0) begin
      n_err++; $display("FAIL midrst_state: got v=%b cnt=%0d expected 0/0", dout_valid, xfer_cnt);
    end
    rst = 1'b0;
    #2;
    step();
    n_vec++;
    if (dout_sel !== 2'd0 || dout_valid !== 1'b1 || dout !== 3'd1) begin
      n_err++; $display("FAIL midrst_first: got sel=%0d v=%b d=%0d expected 0/1/1", dout_sel, dout_valid, dout);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] q[3][$];
    bit           vld[3];
    logic [W-1:0] dat[3];
    int           wt[3];
    int           n_in, n_out;
    logic [2:0]   xin;
    bit           oxfer;
    logic [1:0]   osel;
    logic [W-1:0] odat;
    n_in = 0; n_out = 0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; dat[i] = '0; wt[i] = 0;
    end
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      din_valid  = {vld[2], vld[1], vld[0]};
      din0 = dat[0]; din1 = dat[1]; din2 = dat[2];
      dout_ready = ($urandom_range(0, 3) != 0);
      #2;
      n_vec++;
      if (din_ready !== exp_ready()) begin
        n_err++; $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, din_ready, exp_ready());
      end
      n_vec++;
      if ($countones(din_ready) > 1) begin
        n_err++; $display("FAIL rnd_onehot[%0d]: got %b expected at most one bit", cyc, din_ready);
      end
      xin   = din_valid & din_ready;
      oxfer = dout_valid && dout_ready;
      osel  = dout_sel;
      odat  = dout;
      if (oxfer) begin
        n_out++;
        n_vec++;
        if (osel > 2'd2 || q[osel].size() == 0) begin
          n_err++; $display("FAIL rnd_dup[%0d]: got word %0d from ch %0d expected none pending", cyc, odat, osel);
        end else if (q[osel].pop_front() !== odat) begin
          n_err++; $display("FAIL rnd_order[%0d]: got %0d on ch %0d expected earlier word", cyc, odat, osel);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (xin[i]) begin
          q[i].push_back(dat[i]);
          n_in++;
          wt[i] = 0;
        end else if (!din_valid[i]) begin
          wt[i] = 0;
        end else if (xin != 3'b000) begin
          wt[i]++;
          n_vec++;
          if (wt[i] > 2) begin
            n_err++; $display("FAIL rnd_starve[%0d]: got %0d loads waiting on ch %0d expected <= 2", cyc, wt[i], i);
          end
        end
      end
      step();
      n_vec++;
      if ({dout_valid, dout_sel, dout, xfer_cnt} !== exp_out()) begin
        n_err++; $display("FAIL rnd_out[%0d]: got %h expected %h", cyc,
                          {dout_valid, dout_sel, dout, xfer_cnt}, exp_out());
      end
      for (int i = 0; i < 3; i++) begin
        if (xin[i]) vld[i] = 1'b0;
        if (!vld[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            vld[i] = 1'b1;
            dat[i] = W'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          vld[i] = 1'b0;
        end
      end
    end
    n_vec++;
    if (n_in !== n_out + int'(dout_valid)) begin
      n_err++; $display("FAIL rnd_conserve: got in=%0d out=%0d held=%0d expected in == out+held",
                        n_in, n_out, dout_valid);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_channel();
    test_stall();
    test_idle_withdraw();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
